// File: rtl/game_pkg.sv
// Shared game constants: state encodings, screen size and object box origins.
// Imported by both the object tracker and the VGA renderer so coordinates stay in sync.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE  = 4'd0,
        ST_INTRO1 = 4'd1,
        ST_STAGE1 = 4'd2,
        ST_CLEAR1 = 4'd3,
        ST_STAGE2 = 4'd4,
        ST_CLEAR2 = 4'd5,
        ST_STAGE3 = 4'd6,
        ST_WIN    = 4'd7,
        ST_FAIL   = 4'd8
    } game_state_e;

    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;
    localparam int OBJ_SIZE_DEF = 20;
    localparam int SWITCH_X     = 100;
    localparam int SWITCH_Y     = 100;

    function automatic int key_x(input logic [1:0] idx);
        case (idx)
            2'd0:    return 65;
            2'd1:    return 235;
            2'd2:    return 235;
            default: return 0;
        endcase
    endfunction

    function automatic int key_y(input logic [1:0] idx);
        case (idx)
            2'd0:    return 35;
            2'd1:    return 35;
            2'd2:    return 205;
            default: return 0;
        endcase
    endfunction

    // Half-open box test: [x0, x0+size) x [y0, y0+size).
    function automatic logic in_box(input logic [8:0] x, input logic [8:0] y,
                                    input int x0, input int y0, input int size);
        return (int'(x) >= x0) && (int'(x) < x0 + size) &&
               (int'(y) >= y0) && (int'(y) < y0 + size);
    endfunction

endpackage

// File: rtl/obj_tracker_if.sv
// Bundle between stage control/player logic (master) and the object tracker (slave).
interface obj_tracker_if;
    logic [3:0] state;
    logic       frame_tick;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic       interact;
    logic [1:0] key_find;
    logic       isDark;
    logic       key_pulse;
    logic       all_keys;

    modport master (
        output state, frame_tick, player_x, player_y, interact,
        input  key_find, isDark, key_pulse, all_keys
    );

    modport slave (
        input  state, frame_tick, player_x, player_y, interact,
        output key_find, isDark, key_pulse, all_keys
    );
endinterface

// File: rtl/obj_tracker_light_fsm.sv
// STAGE2 lighting cycle: LIT/DARK alternate every DARK_PERIOD ticks, the switch
// forces a HELD (lit) phase of LIGHT_HOLD ticks before falling back to DARK.
module light_fsm #(
    parameter int DARK_PERIOD = 120,
    parameter int LIGHT_HOLD  = 180
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic frame_tick,
    input  logic switch_hit,
    output logic isDark
);

    localparam int CW = $clog2(DARK_PERIOD);
    localparam int HW = (LIGHT_HOLD > 1) ? $clog2(LIGHT_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DARK_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LIGHT_HOLD - 1);

    localparam logic [1:0] LIT  = 2'd0;
    localparam logic [1:0] DARK = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [1:0]    fsm;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            fsm      <= LIT;
            cnt      <= '0;
            hold_cnt <= '0;
        end else begin
            case (fsm)
                LIT: if (frame_tick) begin
                    if (cnt == CNT_LAST) begin
                        fsm <= DARK;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The switch wins over a period expiry landing in the same cycle.
                DARK: if (switch_hit) begin
                    fsm      <= HELD;
                    hold_cnt <= '0;
                end else if (frame_tick) begin
                    if (cnt == CNT_LAST) begin
                        fsm <= LIT;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        fsm <= DARK;
                        cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: fsm <= LIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) isDark <= 1'b0;
        else        isDark <= (fsm == DARK);
    end

endmodule

// File: rtl/obj_tracker.sv
// Key pickup tracking and STAGE2 darkness control, updated frame-synchronously.
// Optional macro DARK_BLOCKS_PICKUP_EN: pickups are suppressed while isDark is set.
module obj_tracker
    import game_pkg::*;
#(
    parameter int DARK_PERIOD = 120,
    parameter int LIGHT_HOLD  = 180,
    parameter int OBJ_SIZE    = OBJ_SIZE_DEF
) (
    input logic          clk,
    input logic          rst_n,
    obj_tracker_if.slave bus
);

    logic [3:0] prev_state;
    logic [1:0] key_find;
    logic       key_pulse;
    logic       all_keys;
    logic       is_dark;
    logic       in_stage;
    logic       entry;
    logic       key_hit;
    logic       switch_hit;
    logic       dark_block;
    logic       pickup;

    assign in_stage = (bus.state == ST_STAGE1) || (bus.state == ST_STAGE2) ||
                      (bus.state == ST_STAGE3);
    assign entry    = in_stage && (bus.state != prev_state);

    // Only the box of the next key in sequence counts.
    assign key_hit    = in_box(bus.player_x, bus.player_y, key_x(key_find), key_y(key_find), OBJ_SIZE);
    assign switch_hit = bus.interact && in_box(bus.player_x, bus.player_y, SWITCH_X, SWITCH_Y, OBJ_SIZE);

`ifdef DARK_BLOCKS_PICKUP_EN
    assign dark_block = is_dark;
`else
    assign dark_block = 1'b0;
`endif

    assign pickup = bus.frame_tick && in_stage && !entry && (key_find != 2'd3) &&
                    key_hit && !dark_block;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_state <= ST_TITLE;
            key_find   <= 2'd0;
            key_pulse  <= 1'b0;
            all_keys   <= 1'b0;
        end else begin
            prev_state <= bus.state;
            key_pulse  <= 1'b0;
            if (entry || !in_stage) begin
                key_find <= 2'd0;
                all_keys <= 1'b0;
            end else if (pickup) begin
                key_find  <= key_find + 2'd1;
                key_pulse <= 1'b1;
                all_keys  <= (key_find == 2'd2);
            end
        end
    end

    light_fsm #(
        .DARK_PERIOD (DARK_PERIOD),
        .LIGHT_HOLD  (LIGHT_HOLD)
    ) u_light (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     ((bus.state == ST_STAGE2) && !entry),
        .frame_tick (bus.frame_tick),
        .switch_hit (switch_hit),
        .isDark     (is_dark)
    );

    assign bus.key_find  = key_find;
    assign bus.key_pulse = key_pulse;
    assign bus.all_keys  = all_keys;
    assign bus.isDark    = is_dark;

endmodule
